// File: rtl/valu_pkg.sv
// Shared types and constants for the vector ALU lane sequencer and its scalar ALU.
package valu_pkg;

  localparam int unsigned DATA_SIZE_DEFAULT = 8;

  typedef enum logic [2:0] {
    OP_ZERO  = 3'b000,
    OP_XOR   = 3'b001,
    OP_ADD   = 3'b010,
    OP_SUB   = 3'b011,
    OP_MUL   = 3'b100,
    OP_ROR   = 3'b101,
    OP_ROL   = 3'b110,
    OP_INC16 = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } seq_state_t;

endpackage

// File: rtl/valu_lane_sequencer_alu.sv
// Scalar 3-bit-opcode ALU (module alu): combinational result plus negative/zero flags.
module alu
  import valu_pkg::*;
#(
  parameter int unsigned dataSize = DATA_SIZE_DEFAULT
) (
  input  logic [2:0]          op,
  input  logic [dataSize-1:0] operand1,
  input  logic [dataSize-1:0] operand2,
  output logic [dataSize-1:0] result,
  output logic                neg_flag,
  output logic                zero_flag
);

  localparam logic [dataSize-1:0] DsVal = dataSize'(dataSize);
  localparam logic [dataSize-1:0] Inc16 = dataSize'(16);

  logic [dataSize-1:0]   amount;
  logic [2*dataSize-1:0] ror_wide;
  logic [2*dataSize-1:0] rol_wide;

  // Rotates are done by shifting a doubled copy of operand1.
  assign amount   = operand2 % DsVal;
  assign ror_wide = {operand1, operand1} >> amount;
  assign rol_wide = {operand1, operand1} << amount;

  always_comb begin
    result = '0;
    unique case (alu_op_t'(op))
      OP_ZERO:  result = '0;
      OP_XOR:   result = operand1 ^ operand2;
      OP_ADD:   result = operand1 + operand2;
      OP_SUB:   result = operand1 - operand2;
      OP_MUL:   result = operand1 * operand2;
      OP_ROR:   result = ror_wide[dataSize-1:0];
      OP_ROL:   result = rol_wide[2*dataSize-1:dataSize];
      OP_INC16: result = operand1 + Inc16;
      default:  result = '0;
    endcase
  end

  assign zero_flag = (result == '0);
  assign neg_flag  = (operand1[dataSize-1] != result[dataSize-1]) && !zero_flag;

endmodule

// File: rtl/valu_lane_sequencer.sv
// Runs one scalar ALU across all lanes of a vector op, one lane per cycle.
// Optional SCALAR_BROADCAST_EN adds in_bcast/in_scalar to use one scalar as operand2 in all lanes.
module valu_lane_sequencer
  import valu_pkg::*;
#(
  parameter int unsigned DATA_SIZE = DATA_SIZE_DEFAULT,
  parameter int unsigned LANES     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2:0]                 in_op,
  input  logic [LANES*DATA_SIZE-1:0] in_vec_a,
  input  logic [LANES*DATA_SIZE-1:0] in_vec_b,
`ifdef SCALAR_BROADCAST_EN
  input  logic                       in_bcast,
  input  logic [DATA_SIZE-1:0]       in_scalar,
`endif
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*DATA_SIZE-1:0] out_vec,
  output logic [LANES-1:0]           out_neg_mask,
  output logic [LANES-1:0]           out_zero_mask,
  output logic                       busy
);

  localparam int unsigned LaneW = $clog2(LANES);

  seq_state_t                 state_q, state_d;
  logic [LaneW-1:0]           lane_idx_q;
  alu_op_t                    op_q;
  logic [LANES*DATA_SIZE-1:0] a_q, b_q;
  logic [LANES*DATA_SIZE-1:0] out_vec_q;
  logic [LANES-1:0]           neg_q, zero_q;
  logic                       accept, last_lane;
  logic [DATA_SIZE-1:0]       alu_a, alu_b, alu_res;
  logic                       alu_neg, alu_zero;

`ifdef SCALAR_BROADCAST_EN
  logic                       bcast_q;
  logic [DATA_SIZE-1:0]       scalar_q;
`endif

  assign accept    = in_valid && in_ready;
  assign last_lane = (lane_idx_q == LaneW'(LANES - 1));

  assign alu_a = a_q[lane_idx_q*DATA_SIZE +: DATA_SIZE];
`ifdef SCALAR_BROADCAST_EN
  assign alu_b = bcast_q ? scalar_q : b_q[lane_idx_q*DATA_SIZE +: DATA_SIZE];
`else
  assign alu_b = b_q[lane_idx_q*DATA_SIZE +: DATA_SIZE];
`endif

  alu #(
    .dataSize(DATA_SIZE)
  ) u_alu (
    .op       (op_q),
    .operand1 (alu_a),
    .operand2 (alu_b),
    .result   (alu_res),
    .neg_flag (alu_neg),
    .zero_flag(alu_zero)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last_lane) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      lane_idx_q <= '0;
      op_q       <= OP_ZERO;
      a_q        <= '0;
      b_q        <= '0;
      out_vec_q  <= '0;
      neg_q      <= '0;
      zero_q     <= '0;
`ifdef SCALAR_BROADCAST_EN
      bcast_q    <= 1'b0;
      scalar_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q       <= alu_op_t'(in_op);
        a_q        <= in_vec_a;
        b_q        <= in_vec_b;
        lane_idx_q <= '0;
        neg_q      <= '0;
        zero_q     <= '0;
`ifdef SCALAR_BROADCAST_EN
        bcast_q    <= in_bcast;
        scalar_q   <= in_scalar;
`endif
      end
      if (state_q == RUN) begin
        out_vec_q[lane_idx_q*DATA_SIZE +: DATA_SIZE] <= alu_res;
        neg_q[lane_idx_q]  <= alu_neg;
        zero_q[lane_idx_q] <= alu_zero;
        lane_idx_q <= last_lane ? '0 : lane_idx_q + 1'b1;
      end
    end
  end

  assign in_ready      = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign out_valid     = (state_q == DONE);
  assign out_vec       = out_vec_q;
  assign out_neg_mask  = neg_q;
  assign out_zero_mask = zero_q;

endmodule

// File: tb/tb_valu_lane_sequencer.sv
// Directed self-checking bench for valu_lane_sequencer (LANES=4, DATA_SIZE=8).
module tb_valu_lane_sequencer;

  localparam int unsigned DS = 8;
  localparam int unsigned LN = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_op;
  logic [LN*DS-1:0]  in_vec_a, in_vec_b;
  logic              out_valid;
  logic              out_ready;
  logic [LN*DS-1:0]  out_vec;
  logic [LN-1:0]     out_neg_mask, out_zero_mask;
  logic              busy;
`ifdef SCALAR_BROADCAST_EN
  logic              in_bcast;
  logic [DS-1:0]     in_scalar;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  valu_lane_sequencer #(
    .DATA_SIZE(DS),
    .LANES    (LN)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_vec_a     (in_vec_a),
    .in_vec_b     (in_vec_b),
`ifdef SCALAR_BROADCAST_EN
    .in_bcast     (in_bcast),
    .in_scalar    (in_scalar),
`endif
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_vec      (out_vec),
    .out_neg_mask (out_neg_mask),
    .out_zero_mask(out_zero_mask),
    .busy         (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for out_valid, returns number of edges taken (bounded).
  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    in_op    = op;
    in_vec_a = a;
    in_vec_b = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    // Operands must have been captured on the accepting edge.
    in_vec_a = ~a;
    in_vec_b = ~b;
    in_op    = ~op;
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_vec,
                        input logic [3:0] exp_neg, input logic [3:0] exp_zero);
    int n;
    check_eq({tag, ".ready"}, 32'(in_ready), 32'd1);
    issue(op, a, b);
    check_eq({tag, ".busy"}, 32'(busy), 32'd1);
    wait_valid(n);
    check_eq({tag, ".latency"}, 32'(n), 32'd4);
    check_eq({tag, ".vec"}, out_vec, exp_vec);
    check_eq({tag, ".neg"}, 32'(out_neg_mask), 32'(exp_neg));
    check_eq({tag, ".zero"}, 32'(out_zero_mask), 32'(exp_zero));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq({tag, ".valid_drop"}, 32'(out_valid), 32'd0);
    check_eq({tag, ".ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int n;
    logic [31:0] held_vec;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_op     = 3'b000;
    in_vec_a  = '0;
    in_vec_b  = '0;
    out_ready = 1'b0;
`ifdef SCALAR_BROADCAST_EN
    in_bcast  = 1'b0;
    in_scalar = '0;
`endif
    tick();
    tick();
    rst = 1'b0;

    check_eq("rst.vec", out_vec, 32'h0);
    check_eq("rst.neg", 32'(out_neg_mask), 32'h0);
    check_eq("rst.zero", 32'(out_zero_mask), 32'h0);
    check_eq("rst.valid", 32'(out_valid), 32'd0);
    check_eq("rst.busy", 32'(busy), 32'd0);
    check_eq("rst.ready", 32'(in_ready), 32'd1);

    run_op("add", 3'b010, 32'h04030201, 32'h281E140A, 32'h2C21160B, 4'b0000, 4'b0000);
    run_op("sub", 3'b011, 32'h00800505, 32'h00010506, 32'h007F00FF, 4'b0101, 4'b1010);
    run_op("ror", 3'b101, 32'h81818181, 32'h04090001, 32'h18C081C0, 4'b1000, 4'b0000);
    run_op("rol", 3'b110, 32'h81818181, 32'h07010009, 32'hC0038103, 4'b0101, 4'b0000);
    run_op("inc16", 3'b111, 32'h7FF000F8, 32'h12345678, 32'h8F001008, 4'b1001, 4'b0100);
    run_op("mul", 3'b100, 32'h02FF1003, 32'h80FF1005, 32'h0001000F, 4'b0100, 4'b1010);
    run_op("zero", 3'b000, 32'hDEADBEEF, 32'h12345678, 32'h00000000, 4'b0000, 4'b1111);

    // Backpressure: hold DONE for 5 cycles with a new instruction waiting.
    issue(3'b010, 32'h04030201, 32'h281E140A);
    wait_valid(n);
    check_eq("bp.latency", 32'(n), 32'd4);
    in_op    = 3'b001;
    in_vec_a = 32'h0F0F0F0F;
    in_vec_b = 32'hFF00F00F;
    in_valid = 1'b1;
    held_vec = 32'h2C21160B;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("bp.vec", out_vec, held_vec);
      check_eq("bp.valid", 32'(out_valid), 32'd1);
      check_eq("bp.ready", 32'(in_ready), 32'd0);
      check_eq("bp.masks", {out_neg_mask, out_zero_mask}, 32'h0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("bp.idle_busy", 32'(busy), 32'd0);
    check_eq("bp.idle_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check_eq("bp.accepted", 32'(busy), 32'd1);
    wait_valid(n);
    check_eq("bp2.latency", 32'(n), 32'd4);
    check_eq("bp2.vec", out_vec, 32'hF00FFF00);
    check_eq("bp2.neg", 32'(out_neg_mask), 32'b1010);
    check_eq("bp2.zero", 32'(out_zero_mask), 32'b0001);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset while RUN is at lane 2 (lanes 0 and 1 already wrote flags).
    issue(3'b011, 32'h00800505, 32'h00010506);
    tick();
    tick();
    check_eq("mid.partial_masks", {out_neg_mask, out_zero_mask}, 32'h12);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("mid.valid", 32'(out_valid), 32'd0);
    check_eq("mid.masks", {out_neg_mask, out_zero_mask}, 32'h0);
    check_eq("mid.vec", out_vec, 32'h0);
    check_eq("mid.ready", 32'(in_ready), 32'd1);
    check_eq("mid.busy", 32'(busy), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check_eq("mid.no_valid", 32'(out_valid), 32'd0);
    end
    run_op("post_rst", 3'b010, 32'h04030201, 32'h281E140A, 32'h2C21160B, 4'b0000, 4'b0000);

`ifdef SCALAR_BROADCAST_EN
    in_bcast  = 1'b1;
    in_scalar = 8'hFF;
    run_op("bcast", 3'b001, 32'h01020304, 32'hA5C3961E, 32'hFEFDFCFB, 4'b1111, 4'b0000);
    in_bcast  = 1'b0;
    run_op("nobcast", 3'b001, 32'h01020304, 32'h01020304, 32'h00000000, 4'b0000, 4'b1111);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/valu_lane_sequencer.md
Name: valu_lane_sequencer

Overview:
Time-multiplexes one scalar 3-bit-opcode ALU (the existing alu module) across the LANES elements of a vector instruction, one lane per cycle. It accepts a packed vector operation over a valid/ready handshake and returns the packed result vector plus per-lane negative and zero flag masks. It sits in the execute stage between the decode/issue register and the writeback mux.

Parameters:
DATA_SIZE, 8, element width in bits; passed to the internal ALU.
LANES, 4, elements per vector; must be >= 2. Lane counter width is $clog2(LANES).

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, synchronous, active-high
in_valid  input  1  issue offers an instruction
in_ready  output  1  sequencer can accept; high only in IDLE
in_op  input  3  ALU opcode: 000 zero, 001 xor, 010 add, 011 sub, 100 mul, 101 rotate-right, 110 rotate-left, 111 add 16
in_vec_a  input  LANES*DATA_SIZE  operand1 vector; lane i is bits [i*DATA_SIZE +: DATA_SIZE]
in_vec_b  input  LANES*DATA_SIZE  operand2 vector, same packing
out_valid  output  1  result available
out_ready  input  1  writeback accepts the result
out_vec  output  LANES*DATA_SIZE  result vector, same packing
out_neg_mask  output  LANES  per-lane ALU neg_flag
out_zero_mask  output  LANES  per-lane ALU zero_flag
busy  output  1  high in RUN or DONE

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- FSM states: IDLE, RUN, DONE.
- Reset: state=IDLE, lane_idx=0, out_vec=0, out_neg_mask=0, out_zero_mask=0, out_valid=0, busy=0, in_ready=1 (combinational from IDLE).
- IDLE: on in_valid&&in_ready, latch op, vec_a and vec_b into internal registers, set lane_idx=0, go to RUN. Clear out_neg_mask and out_zero_mask on the same edge. in_vec_* are not sampled after acceptance.
- RUN:
  - The ALU sees latched op, lane lane_idx of a, and lane lane_idx of b.
  - At each edge, ALU result is written to out_vec lane lane_idx; neg_flag and zero_flag are written to bit lane_idx of the masks.
  - lane_idx increments. When lane_idx==LANES-1, go to DONE and reset lane_idx to 0.
- DONE: out_valid=1. out_vec and masks are held stable while out_ready=0. On out_ready, go to IDLE with out_valid=0 on the next cycle.
- Latency: out_valid is first high exactly LANES edges after the accepting edge. Throughput is one instruction per LANES+2 cycles. No overlap: in_ready=0 in RUN and DONE.
- ALU semantics are inherited unchanged:
  - Results wrap modulo 2^DATA_SIZE; mul keeps the low DATA_SIZE bits.
  - Rotate amount is operand2 mod DATA_SIZE; amount 0 returns operand1.
  - zero = (result==0).
  - neg = (msb(op1) != msb(result)) && !zero.
  - Opcode 000 yields 0 with zero=1 in every lane and still takes LANES cycles.
- Reset mid-RUN or mid-DONE: the instruction is discarded, all outputs return to reset values, and no out_valid pulse is produced.
- in_valid while not in IDLE is ignored; issue must hold it until in_ready.
- out_ready while not in DONE has no effect.
- Partial results are visible on out_vec during RUN but are valid only when out_valid=1.

Optional Feature:
SCALAR_BROADCAST_EN
- Defined: adds input in_bcast (1) and in_scalar (DATA_SIZE). When in_bcast=1 at acceptance, in_scalar is latched and used as operand2 for every lane, and in_vec_b is ignored.
- Undefined: those ports do not exist; operand2 is always the lane of in_vec_b.

Decomposition:
- Package valu_pkg:
  - alu_op_t enum (OP_ZERO=3'b000, OP_XOR, OP_ADD, OP_SUB, OP_MUL, OP_ROR, OP_ROL, OP_INC16).
  - seq_state_t enum {IDLE, RUN, DONE}.
  - Shared DATA_SIZE default constant.
- Sub-module: one instance of the existing alu (dataSize=DATA_SIZE), driven from the lane-select muxes. No other sub-modules.

Test Plan:
1. Add, LANES=4, DATA_SIZE=8: a={4,3,2,1}, b={40,30,20,10} (lane3..0) -> out_vec={44,33,22,11}, zero_mask=0, neg_mask=0; out_valid exactly 4 edges after accept.
2. Sub: a lanes={0x05,0x05,0x80,0x00}, b={0x06,0x05,0x01,0x00} (lane0..3) -> results {0xFF,0x00,0x7F,0x00}, neg_mask=4'b0101, zero_mask=4'b1010.
3. Rotates: op 101, a=0x81, b=1 -> 0xC0; op 110, a=0x81, b=9 -> 0x03; b=0 -> 0x81. op 111, a=0xF8 -> 0x08 with neg=1.
4. Backpressure: out_ready=0 for 5 cycles in DONE -> out_vec and masks constant, out_valid=1, in_ready=0, and a held in_valid is not accepted until the cycle after the out_ready handshake.
5. Reset in RUN at lane 2 -> next cycle state IDLE, out_valid=0, masks=0, in_ready=1; the following instruction completes correctly.
6. With SCALAR_BROADCAST_EN: xor, a={1,2,3,4}, in_bcast=1, in_scalar=0xFF -> {0xFE,0xFD,0xFC,0xFB}; in_vec_b garbage has no effect.
